router_pkt_reader: RTL and testbench
====================================

ROUTER_PKT_READER -- requirements
Module: router_pkt_reader

Interface
REQ-001 SHALL have parameter PORT_ID, default 2'd0, router output port this reader drains; expected header address.
REQ-002 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-003 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port vld_out  input  1  router output FIFO non-empty.
REQ-006 SHALL have port data_out  input  8  router FIFO read data, valid exactly 1 cycle after a sampled read_enb.
REQ-007 SHALL have port read_enb  output  1  FIFO pop request.
REQ-008 SHALL have port m_data  output  8  payload byte to downstream.
REQ-009 SHALL have port m_valid  output  1  m_data valid.
REQ-010 SHALL have port m_last  output  1  marks the final payload byte.
REQ-011 SHALL have port m_ready  input  1  downstream accept; a transfer occurs when m_valid and m_ready are both high.
REQ-012 SHALL have port pkt_len  output  6  payload length of the current or last header.
REQ-013 SHALL have port pkt_done  output  1  one-cycle pulse when the parity byte is checked.
REQ-014 SHALL have port parity_err  output  1  one-cycle pulse with pkt_done on parity mismatch.
REQ-015 SHALL have port addr_err  output  1  one-cycle pulse with pkt_done when header addr != PORT_ID.
REQ-016 SHALL have port pkt_count  output  CNT_W  saturating count of completed packets.
REQ-017 SHALL have port err_count  output  CNT_W  saturating count of packets with any error.

Function
REQ-018 SHALL parse the packet format header {len[7:2], addr[1:0]}, then len payload bytes, then one parity byte equal to the XOR of header and all payload bytes.
REQ-019 SHALL implement the FSM IDLE -> HDR -> PAYLOAD -> PARITY -> IDLE; HDR with len==0 goes directly to PARITY.
REQ-020 SHALL assert read_enb only when vld_out=1 and the byte is needed by the current state, and during PAYLOAD only when output-buffer occupancy plus in-flight reads < 2.
REQ-021 SHALL hold at most one read in flight and never issue a read for bytes beyond the current packet's parity byte.
REQ-022 SHALL deliver payload through a 2-entry FIFO output buffer; bytes are presented in order and m_data/m_last are held stable while m_valid=1 and m_ready=0.
REQ-023 SHALL assert m_last with payload byte number len (1-based); header and parity bytes never appear on m_data.
REQ-024 SHALL accumulate XOR parity from the header through the last payload byte, compare it with the parity byte, and pulse pkt_done the cycle after the parity byte arrives.
REQ-025 SHALL pulse pkt_done independently of m_ready; a new header read may start in the cycle pkt_done pulses.
REQ-026 SHALL increment pkt_count on every pkt_done, increment err_count when parity_err or addr_err is set, and saturate both at all-ones.
REQ-027 SHALL handle a gap where vld_out=0 mid-packet by stalling in the current state with no byte lost or duplicated.
REQ-028 SHALL hold read_enb low for the whole cycle while the output buffer is full, even if vld_out=1.

Reset
REQ-029 SHALL, while reset=1, drive read_enb, m_valid, m_last, pkt_done, parity_err and addr_err to 0, clear m_data, pkt_len, pkt_count and err_count to 0, empty the buffer, set the FSM to IDLE and discard any in-flight read.
REQ-030 SHALL abandon a packet when reset is asserted mid-packet, without producing a pkt_done for it.

Structure
REQ-031 SHALL take the FSM state enum, header field positions and HDR_LEN_W=6 from the shared package router_pkg.
REQ-032 SHALL implement the 2-entry output buffer as the sub-module router_skid_buf.

Verification
REQ-033 SHALL cover: PORT_ID=2, header 8'h42 (len 16, addr 2), 16 random bytes, correct parity, m_ready=1 -> 16 bytes in order, m_last on byte 16, pkt_done=1, parity_err=0, pkt_count=1.
REQ-034 SHALL cover: same packet with parity byte bit0 flipped -> parity_err and pkt_done in the same cycle, err_count=1.
REQ-035 SHALL cover: header 8'h41 with PORT_ID=2 -> addr_err pulse at pkt_done, payload still forwarded.
REQ-036 SHALL cover: m_ready=0 for 10 cycles mid-payload -> at most 2 bytes buffered, read_enb=0 throughout, no data loss after release.
REQ-037 SHALL cover: header 8'h02 (len 0) then parity 8'h02 -> no m_valid, pkt_done=1, parity_err=0.
REQ-038 SHALL cover: reset pulsed after the 5th payload byte -> all outputs 0 next cycle; the next full packet is processed correctly.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router output-port packet reader.
// Header layout is {len[7:2], addr[1:0]}; one parity byte follows the payload.
// Helpers pull the header fields so callers never hard-code bit positions.
package router_pkg;

  localparam int BYTE_W       = 8;
  localparam int HDR_LEN_W    = 6;
  localparam int HDR_ADDR_W   = 2;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_LSB = 0;

  // Reader phase: which byte the next FIFO read (or the pending one) belongs to.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // between packets, next read is a header
    ST_HDR     = 2'd1,  // header read in flight, length not yet known
    ST_PAYLOAD = 2'd2,  // payload reads outstanding
    ST_PARITY  = 2'd3   // all payload requested, next read is the parity byte
  } rd_state_t;

  // Tag carried with the single in-flight read so the arriving byte is routed correctly.
  typedef enum logic [1:0] {
    BT_HDR      = 2'd0,
    BT_PAY      = 2'd1,
    BT_PAY_LAST = 2'd2,
    BT_PAR      = 2'd3
  } byte_kind_t;

  function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [BYTE_W-1:0] hdr);
    return hdr[HDR_LEN_LSB +: HDR_LEN_W];
  endfunction

  function automatic logic [HDR_ADDR_W-1:0] hdr_addr(input logic [BYTE_W-1:0] hdr);
    return hdr[HDR_ADDR_LSB +: HDR_ADDR_W];
  endfunction

endpackage

// File: rtl/router_skid_buf.sv
// Two-entry output FIFO between the packet reader and the downstream valid/ready port.
// Latency: a pushed entry is visible on vld_o/dat_o the cycle after the push.
// Backpressure: head entry held stable while rdy_i=0; full_o tells the writer to stop.
module router_skid_buf #(
  parameter int W = 9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o,
  input  logic         rdy_i,
  output logic [1:0]   cnt_o,
  output logic         full_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         pop;
  logic         push_ok;

  assign vld_o   = (cnt_q != 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign dat_o   = mem_q[rd_ptr_q];
  assign cnt_o   = cnt_q;
  assign pop     = vld_o && rdy_i;
  // A push into a full buffer is only safe when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop);

  // Storage, pointers and occupancy; entries clear on reset so the head reads as zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/router_pkt_reader.sv
// Drains one router output FIFO: parses header/payload/parity, forwards payload, keeps stats.
// Latency: a FIFO byte reaches m_data 2 cycles after its read_enb; pkt_done 1 cycle after parity.
// Backpressure: m_ready low fills the 2-entry buffer, after which read_enb is held low.
module router_pkt_reader
  import router_pkg::*;
#(
  parameter logic [HDR_ADDR_W-1:0] PORT_ID = 2'd0,
  parameter int                    CNT_W   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 vld_out,
  input  logic [BYTE_W-1:0]    data_out,
  output logic                 read_enb,
  output logic [BYTE_W-1:0]    m_data,
  output logic                 m_valid,
  output logic                 m_last,
  input  logic                 m_ready,
  output logic [HDR_LEN_W-1:0] pkt_len,
  output logic                 pkt_done,
  output logic                 parity_err,
  output logic                 addr_err,
  output logic [CNT_W-1:0]     pkt_count,
  output logic [CNT_W-1:0]     err_count
);

  localparam logic [CNT_W-1:0]     CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     CNT_MAX = '1;
  localparam logic [HDR_LEN_W-1:0] LEN_ONE = {{(HDR_LEN_W-1){1'b0}}, 1'b1};
  localparam logic [HDR_LEN_W-1:0] LEN_ZERO = '0;

  rd_state_t             state_q;
  byte_kind_t            kind_q;
  logic                  inflight_q;
  logic [HDR_LEN_W-1:0]  rem_q;
  logic [BYTE_W-1:0]     par_acc_q;
  logic                  addr_bad_q;
  logic [HDR_LEN_W-1:0]  pkt_len_q;
  logic                  pkt_done_q;
  logic                  parity_err_q;
  logic                  addr_err_q;
  logic [CNT_W-1:0]      pkt_count_q;
  logic [CNT_W-1:0]      err_count_q;

  logic                  rd_req;
  logic                  buf_push;
  logic                  buf_full;
  logic [1:0]            buf_cnt;
  logic [1:0]            occ_sum;
  logic [BYTE_W:0]       buf_dat;
  logic                  parity_bad;

  // Bytes already committed to the buffer: stored entries plus the one arriving now.
  assign occ_sum    = buf_cnt + {1'b0, inflight_q};
  assign parity_bad = (par_acc_q != data_out);
  assign buf_push   = inflight_q && ((kind_q == BT_PAY) || (kind_q == BT_PAY_LAST));

  // Pop request: only when the FIFO has data, the current phase needs a byte and the buffer has room.
  always_comb begin
    rd_req = 1'b0;
    if (vld_out && !buf_full) begin
      case (state_q)
        ST_IDLE:    rd_req = !inflight_q;        // wait for the previous parity byte to land
        ST_HDR:     rd_req = 1'b0;               // length unknown until the header arrives
        ST_PAYLOAD: rd_req = (occ_sum < 2'd2);
        ST_PARITY:  rd_req = 1'b1;
        default:    rd_req = 1'b0;
      endcase
    end
  end

  assign read_enb = rd_req && !reset;

  // Reader FSM: issue side advances the phase, arrival side parses the byte returned by the last read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      kind_q       <= BT_HDR;
      inflight_q   <= 1'b0;
      rem_q        <= LEN_ZERO;
      par_acc_q    <= '0;
      addr_bad_q   <= 1'b0;
      pkt_len_q    <= LEN_ZERO;
      pkt_done_q   <= 1'b0;
      parity_err_q <= 1'b0;
      addr_err_q   <= 1'b0;
      pkt_count_q  <= '0;
      err_count_q  <= '0;
    end else begin
      pkt_done_q   <= 1'b0;
      parity_err_q <= 1'b0;
      addr_err_q   <= 1'b0;
      inflight_q   <= rd_req;

      if (rd_req) begin
        case (state_q)
          ST_IDLE: begin
            kind_q  <= BT_HDR;
            state_q <= ST_HDR;
          end
          ST_PAYLOAD: begin
            rem_q <= rem_q - LEN_ONE;
            if (rem_q == LEN_ONE) begin
              kind_q  <= BT_PAY_LAST;
              state_q <= ST_PARITY;
            end else begin
              kind_q  <= BT_PAY;
            end
          end
          ST_PARITY: begin
            kind_q  <= BT_PAR;
            state_q <= ST_IDLE;
          end
          default: begin
            kind_q <= kind_q;
          end
        endcase
      end

      // No read is issued in ST_HDR, so header arrival never races the issue side.
      if (inflight_q) begin
        case (kind_q)
          BT_HDR: begin
            par_acc_q  <= data_out;
            pkt_len_q  <= hdr_len(data_out);
            rem_q      <= hdr_len(data_out);
            addr_bad_q <= (hdr_addr(data_out) != PORT_ID);
            state_q    <= (hdr_len(data_out) == LEN_ZERO) ? ST_PARITY : ST_PAYLOAD;
          end
          BT_PAY, BT_PAY_LAST: begin
            par_acc_q <= par_acc_q ^ data_out;
          end
          BT_PAR: begin
            pkt_done_q   <= 1'b1;
            parity_err_q <= parity_bad;
            addr_err_q   <= addr_bad_q;
            if (pkt_count_q != CNT_MAX) begin
              pkt_count_q <= pkt_count_q + CNT_ONE;
            end
            if ((parity_bad || addr_bad_q) && (err_count_q != CNT_MAX)) begin
              err_count_q <= err_count_q + CNT_ONE;
            end
          end
          default: begin
            par_acc_q <= par_acc_q;
          end
        endcase
      end
    end
  end

  router_skid_buf #(
    .W (BYTE_W + 1)
  ) u_obuf (
    .clock      (clock),
    .reset      (reset),
    .push_i     (buf_push),
    .push_dat_i ({(kind_q == BT_PAY_LAST), data_out}),
    .vld_o      (m_valid),
    .dat_o      (buf_dat),
    .rdy_i      (m_ready),
    .cnt_o      (buf_cnt),
    .full_o     (buf_full)
  );

  assign m_data     = buf_dat[BYTE_W-1:0];
  assign m_last     = buf_dat[BYTE_W];
  assign pkt_len    = pkt_len_q;
  assign pkt_done   = pkt_done_q;
  assign parity_err = parity_err_q;
  assign addr_err   = addr_err_q;
  assign pkt_count  = pkt_count_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_router_pkt_reader.sv
// Bench for router_pkt_reader with PORT_ID=2: queue-based router FIFO, payload scoreboard,
// per-packet event model (parity/addr error, length) and packet/error counters.
module tb_router_pkt_reader;

  localparam int PID = 2;

  typedef struct {
    logic [7:0] d;
    logic       last;
  } exp_byte_t;

  typedef struct {
    logic perr;
    logic aerr;
    int   len;
  } exp_ev_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        vld_out = 1'b0;
  logic [7:0]  data_out = 8'h00;
  logic        m_ready = 1'b1;
  logic        read_enb;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic [5:0]  pkt_len;
  logic        pkt_done;
  logic        parity_err;
  logic        addr_err;
  logic [15:0] pkt_count;
  logic [15:0] err_count;

  int tests = 0;
  int fails = 0;

  logic [7:0] fifo [$];
  exp_byte_t  exp_q [$];
  exp_ev_t    ev_q [$];
  int         exp_pkts = 0;
  int         exp_errs = 0;
  int         xfer_cnt = 0;
  int         rd_pops = 0;
  int         rdy_mode = 0;   // 0: always ready, 1: never ready, 2: random
  bit         gap_en = 1'b0;
  bit         stalled_prev = 1'b0;
  logic [7:0] prev_dat = 8'h00;
  logic       prev_last = 1'b0;

  router_pkt_reader #(
    .PORT_ID (2'd2),
    .CNT_W   (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .vld_out    (vld_out),
    .data_out   (data_out),
    .read_enb   (read_enb),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .pkt_len    (pkt_len),
    .pkt_done   (pkt_done),
    .parity_err (parity_err),
    .addr_err   (addr_err),
    .pkt_count  (pkt_count),
    .err_count  (err_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Router FIFO: a sampled read pops the head, which appears on data_out the next cycle.
  always @(posedge clock) begin
    if (read_enb && !reset) begin
      rd_pops++;
      check("rd_needs_vld", int'(vld_out), 1);
      if (fifo.size() > 0) data_out <= fifo.pop_front();
    end
  end

  // Drive ready/valid for the coming edge, then score the transfer and completion events.
  always @(negedge clock) begin : mon
    exp_byte_t eb;
    exp_ev_t   ev;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'b0;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    vld_out = (fifo.size() > 0) && !(gap_en && ($urandom_range(0, 3) == 0));
    if (!reset) begin
      if (stalled_prev) begin
        check("hold_valid", int'(m_valid), 1);
        check("hold_data", int'(m_data), int'(prev_dat));
        check("hold_last", int'(m_last), int'(prev_last));
      end
      if (m_valid && m_ready) begin
        check("byte_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          eb = exp_q.pop_front();
          check("m_data", int'(m_data), int'(eb.d));
          check("m_last", int'(m_last), int'(eb.last));
        end
        xfer_cnt++;
      end
      if (pkt_done) begin
        check("event_expected", int'(ev_q.size() > 0), 1);
        if (ev_q.size() > 0) begin
          ev = ev_q.pop_front();
          exp_pkts++;
          if (ev.perr || ev.aerr) exp_errs++;
          check("parity_err", int'(parity_err), int'(ev.perr));
          check("addr_err", int'(addr_err), int'(ev.aerr));
          check("pkt_len", int'(pkt_len), ev.len);
          check("pkt_count", int'(pkt_count), exp_pkts);
          check("err_count", int'(err_count), exp_errs);
        end
      end else if (parity_err || addr_err) begin
        check("err_without_done", int'(parity_err) + int'(addr_err), 0);
      end
      stalled_prev = m_valid && !m_ready;
      prev_dat     = m_data;
      prev_last    = m_last;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  // Queue one packet (header, random payload, parity) and record what must come out.
  task automatic send_pkt(input logic [7:0] hdr, input bit corrupt);
    int         len = int'(hdr) / 4;
    logic [7:0] x = hdr;
    logic [7:0] b;
    exp_byte_t  eb;
    exp_ev_t    ev;
    fifo.push_back(hdr);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      x = x ^ b;
      fifo.push_back(b);
      eb.d    = b;
      eb.last = (i == len - 1);
      exp_q.push_back(eb);
    end
    fifo.push_back(corrupt ? (x ^ 8'h01) : x);
    ev.perr = corrupt;
    ev.aerr = ((int'(hdr) % 4) != PID);
    ev.len  = len;
    ev_q.push_back(ev);
  endtask

  task automatic wait_drain(input string tag);
    int c = 0;
    while ((exp_q.size() != 0 || ev_q.size() != 0) && c < 4000) begin
      @(negedge clock);
      c++;
    end
    repeat (3) @(negedge clock);
    #1;
    check({tag, "_bytes_left"}, exp_q.size(), 0);
    check({tag, "_events_left"}, ev_q.size(), 0);
    check({tag, "_fifo_left"}, fifo.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_read_enb"}, int'(read_enb), 0);
    check({tag, "_m_valid"}, int'(m_valid), 0);
    check({tag, "_m_last"}, int'(m_last), 0);
    check({tag, "_m_data"}, int'(m_data), 0);
    check({tag, "_pkt_len"}, int'(pkt_len), 0);
    check({tag, "_pkt_done"}, int'(pkt_done), 0);
    check({tag, "_parity_err"}, int'(parity_err), 0);
    check({tag, "_addr_err"}, int'(addr_err), 0);
    check({tag, "_pkt_count"}, int'(pkt_count), 0);
    check({tag, "_err_count"}, int'(err_count), 0);
  endtask

  initial begin
    int base;
    int pops0;
    int len;
    int addr;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    check_outputs_zero("rst");
    @(posedge clock); #1;
    reset = 1'b0;

    // Good packet to this port: 16 bytes, last on byte 16, no errors
    send_pkt(8'h42, 1'b0);
    wait_drain("good");
    check("good_pkt_count", int'(pkt_count), 1);
    check("good_err_count", int'(err_count), 0);

    // Parity byte with bit0 flipped
    send_pkt(8'h42, 1'b1);
    wait_drain("perr");
    check("perr_err_count", int'(err_count), 1);

    // Header addressed to port 1: payload still forwarded, addr_err at completion
    send_pkt(8'h41, 1'b0);
    wait_drain("aerr");
    check("aerr_err_count", int'(err_count), 2);
    check("aerr_pkt_count", int'(pkt_count), 3);

    // Downstream stalls for 10 cycles mid-payload
    base = xfer_cnt;
    send_pkt(8'h42, 1'b0);
    for (int c = 0; c < 400 && xfer_cnt < base + 4; c++) @(posedge clock);
    #1;
    rdy_mode = 1;
    pops0 = rd_pops;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock); #1;
      if (i >= 3) begin
        check("stall_read_enb", int'(read_enb), 0);
        check("stall_m_valid", int'(m_valid), 1);
      end
    end
    check("stall_reads_le2", int'((rd_pops - pops0) <= 2), 1);
    rdy_mode = 0;
    wait_drain("stall");
    check("stall_pkt_count", int'(pkt_count), 4);

    // Zero-length packet
    send_pkt(8'h02, 1'b0);
    wait_drain("len0");
    check("len0_pkt_count", int'(pkt_count), 5);
    check("len0_err_count", int'(err_count), 2);

    // Reset after the 5th payload byte, then a clean packet
    base = xfer_cnt;
    send_pkt(8'h42, 1'b0);
    for (int c = 0; c < 400 && xfer_cnt < base + 5; c++) @(posedge clock);
    #1;
    check("rst_mid_5_bytes", xfer_cnt - base, 5);
    reset = 1'b1;
    exp_q.delete();
    ev_q.delete();
    fifo.delete();
    exp_pkts = 0;
    exp_errs = 0;
    @(negedge clock); #1;
    check_outputs_zero("rst_mid");
    @(posedge clock); #1;
    reset = 1'b0;
    send_pkt(8'h42, 1'b0);
    wait_drain("after_rst");
    check("after_rst_pkt_count", int'(pkt_count), 1);
    check("after_rst_err_count", int'(err_count), 0);

    // Randomized back-to-back packets with random backpressure and FIFO gaps
    rdy_mode = 2;
    gap_en   = 1'b1;
    for (int p = 0; p < 24; p++) begin
      len  = $urandom_range(0, 20);
      addr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : PID;
      send_pkt(8'(len * 4 + addr), ($urandom_range(0, 3) == 0));
    end
    wait_drain("rand");
    check("rand_pkt_count", int'(pkt_count), exp_pkts);
    check("rand_err_count", int'(err_count), exp_errs);
    check("rand_pkts_total", exp_pkts, 25);
    rdy_mode = 0;
    gap_en   = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
